// File: rtl/tut3_verilog_gcd_GcdMsgs.sv
// GCD message formats shared by the GCD unit and its client.
// Field slices for request and command bundles.
package tut3_verilog_gcd_GcdMsgs;

    localparam int OP_NBITS  = 16;
    localparam int REQ_NBITS = 32;
    localparam int CMD_NBITS = 48;

    localparam int REQ_A_MSB = 31;
    localparam int REQ_A_LSB = 16;
    localparam int REQ_B_MSB = 15;
    localparam int REQ_B_LSB = 0;

    localparam int CMD_A_MSB   = 47;
    localparam int CMD_A_LSB   = 32;
    localparam int CMD_B_MSB   = 31;
    localparam int CMD_B_LSB   = 16;
    localparam int CMD_CNT_MSB = 15;
    localparam int CMD_CNT_LSB = 0;

endpackage

// File: rtl/tut3_verilog_gcd_GcdClientCtrl.sv
// Batch client control: IDLE/RUN/DONE FSM and Moore val/rdy outputs.
// Fire strobes combine those outputs with the partner's val/rdy.
module tut3_verilog_gcd_GcdClientCtrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_val,
    input  logic       count_zero,
    input  logic       req_go,
    input  logic       resp_go,
    input  logic       recv_last,
    input  logic       req_rdy,
    input  logic       resp_val,
    input  logic       done_rdy,
    output logic       cmd_rdy,
    output logic       req_val,
    output logic       resp_rdy,
    output logic       done_val,
    output logic       load,
    output logic       issue_en,
    output logic       recv_en,
    output logic [1:0] state
);

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_RUN  = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    logic [1:0] state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: begin
                if (load) begin
                    state_next = count_zero ? STATE_DONE : STATE_RUN;
                end
            end
            STATE_RUN: begin
                if (recv_en && recv_last) begin
                    state_next = STATE_DONE;
                end
            end
            STATE_DONE: begin
                if (done_val && done_rdy) begin
                    state_next = STATE_IDLE;
                end
            end
            default: state_next = 'x;
        endcase
    end

    always_comb begin
        cmd_rdy  = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        done_val = 1'b0;
        case (state)
            STATE_IDLE: cmd_rdy = 1'b1;
            STATE_RUN: begin
                req_val  = req_go;
                resp_rdy = resp_go;
            end
            STATE_DONE: done_val = 1'b1;
            default: begin
                cmd_rdy  = 1'bx;
                req_val  = 1'bx;
                resp_rdy = 1'bx;
                done_val = 1'bx;
            end
        endcase
    end

    assign load     = cmd_val && cmd_rdy;
    assign issue_en = req_val && req_rdy;
    assign recv_en  = resp_val && resp_rdy;

endmodule

// File: rtl/vc_cells.sv
// Basic datapath cells: enabled register, adder, less-than comparator.
// The register clears synchronously on reset.
module vc_EnReg #(
    parameter int p_nbits = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module vc_Adder #(
    parameter int p_nbits = 16
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] out
);

    assign out = in0 + in1;

endmodule

module vc_LtComparator #(
    parameter int p_nbits = 16
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic               out
);

    assign out = (in0 < in1);

endmodule

// File: rtl/tut3_verilog_gcd_gcd_client.sv
// GCD batch client: issues {a_base+i, b_base} requests, sums the results,
// and reports the 32-bit total on the done stream.
module tut3_verilog_gcd_gcd_client
    import tut3_verilog_gcd_GcdMsgs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic [47:0] cmd_msg,
    output logic        req_val,
    input  logic        req_rdy,
    output logic [31:0] req_msg,
    input  logic        resp_val,
    output logic        resp_rdy,
    input  logic [15:0] resp_msg,
    output logic        done_val,
    input  logic        done_rdy,
    output logic [31:0] done_msg
);

    logic [OP_NBITS-1:0] a_base;
    logic [OP_NBITS-1:0] b_base;
    logic [OP_NBITS-1:0] count;
    logic [OP_NBITS-1:0] issue_cnt;
    logic [OP_NBITS-1:0] issue_next;
    logic [OP_NBITS-1:0] issue_d;
    logic [OP_NBITS-1:0] recv_cnt;
    logic [OP_NBITS-1:0] recv_next;
    logic [OP_NBITS-1:0] recv_d;
    logic [OP_NBITS-1:0] a_cur;
    logic [31:0]         sum;
    logic [31:0]         sum_next;
    logic [31:0]         sum_d;

    logic       load;
    logic       issue_en;
    logic       recv_en;
    logic       req_go;
    logic       resp_go;
    logic       recv_last;
    logic       count_zero;
    logic [1:0] state;

    vc_EnReg #(OP_NBITS) a_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (cmd_msg[CMD_A_MSB:CMD_A_LSB]),
        .q     (a_base)
    );

    vc_EnReg #(OP_NBITS) b_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (cmd_msg[CMD_B_MSB:CMD_B_LSB]),
        .q     (b_base)
    );

    vc_EnReg #(OP_NBITS) cnt_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (cmd_msg[CMD_CNT_MSB:CMD_CNT_LSB]),
        .q     (count)
    );

    // A new command clears the counters and sum via the d-input mux.
    assign issue_d = load ? '0 : issue_next;
    assign recv_d  = load ? '0 : recv_next;
    assign sum_d   = load ? '0 : sum_next;

    vc_Adder #(OP_NBITS) issue_inc (
        .in0 (issue_cnt),
        .in1 (16'd1),
        .out (issue_next)
    );

    vc_EnReg #(OP_NBITS) issue_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load || issue_en),
        .d     (issue_d),
        .q     (issue_cnt)
    );

    vc_Adder #(OP_NBITS) recv_inc (
        .in0 (recv_cnt),
        .in1 (16'd1),
        .out (recv_next)
    );

    vc_EnReg #(OP_NBITS) recv_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load || recv_en),
        .d     (recv_d),
        .q     (recv_cnt)
    );

    vc_Adder #(32) sum_add (
        .in0 (sum),
        .in1 ({16'd0, resp_msg}),
        .out (sum_next)
    );

    vc_EnReg #(32) sum_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load || recv_en),
        .d     (sum_d),
        .q     (sum)
    );

    vc_LtComparator #(OP_NBITS) req_lt (
        .in0 (issue_cnt),
        .in1 (count),
        .out (req_go)
    );

    vc_LtComparator #(OP_NBITS) resp_lt (
        .in0 (recv_cnt),
        .in1 (count),
        .out (resp_go)
    );

    vc_Adder #(OP_NBITS) a_add (
        .in0 (a_base),
        .in1 (issue_cnt),
        .out (a_cur)
    );

    assign recv_last  = (recv_next == count);
    assign count_zero = (cmd_msg[CMD_CNT_MSB:CMD_CNT_LSB] == '0);
    assign req_msg    = {a_cur, b_base};
    assign done_msg   = sum;

    tut3_verilog_gcd_GcdClientCtrl ctrl (
        .clk        (clk),
        .reset      (reset),
        .cmd_val    (cmd_val),
        .count_zero (count_zero),
        .req_go     (req_go),
        .resp_go    (resp_go),
        .recv_last  (recv_last),
        .req_rdy    (req_rdy),
        .resp_val   (resp_val),
        .done_rdy   (done_rdy),
        .cmd_rdy    (cmd_rdy),
        .req_val    (req_val),
        .resp_rdy   (resp_rdy),
        .done_val   (done_val),
        .load       (load),
        .issue_en   (issue_en),
        .recv_en    (recv_en),
        .state      (state)
    );

`ifndef SYNTHESIS
    function automatic string vr(input logic v, input logic r);
        if (v && r) return "#";
        if (v)      return "v";
        if (r)      return "r";
        return ".";
    endfunction

    function automatic string line_trace();
        string st;
        case (state)
            2'd0:    st = "I";
            2'd1:    st = "R";
            2'd2:    st = "D";
            default: st = "?";
        endcase
        return $sformatf("%s%h|%s%h|%s%h|%s",
                         vr(cmd_val, cmd_rdy), cmd_msg,
                         vr(req_val, req_rdy), req_msg,
                         vr(resp_val, resp_rdy), resp_msg, st);
    endfunction
`endif

endmodule

// File: tb/tb_tut3_verilog_gcd_gcd_client.sv
// Directed bench for the GCD batch client with a behavioural GCD unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_tut3_verilog_gcd_gcd_client;

    logic        clk;
    logic        reset;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [47:0] cmd_msg;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [15:0] resp_msg;
    logic        done_val;
    logic        done_rdy;
    logic [31:0] done_msg;

    int n_checks = 0;
    int n_fail   = 0;

    tut3_verilog_gcd_gcd_client dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_val  (cmd_val),
        .cmd_rdy  (cmd_rdy),
        .cmd_msg  (cmd_msg),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .done_val (done_val),
        .done_rdy (done_rdy),
        .done_msg (done_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural GCD unit: in-order queue, one result per request.
    logic [15:0] q_mem [0:15];
    logic [3:0]  q_head;
    logic [3:0]  q_tail;
    logic [31:0] log_mem [0:63];
    int          log_n = 0;

    function automatic logic [15:0] gcd(input logic [15:0] a,
                                        input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    assign resp_val = (q_head != q_tail);
    assign resp_msg = q_mem[q_head];

    always @(posedge clk) begin
        if (reset) begin
            q_head <= 4'd0;
            q_tail <= 4'd0;
        end else begin
            if (req_val && req_rdy) begin
                q_mem[q_tail]  <= gcd(req_msg[31:16], req_msg[15:0]);
                q_tail         <= q_tail + 4'd1;
                log_mem[log_n] <= req_msg;
                log_n          <= log_n + 1;
            end
            if (resp_val && resp_rdy) begin
                q_head <= q_head + 4'd1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] n);
        cmd_val = 1'b1;
        cmd_msg = {a, b, n};
        tick();
        cmd_val = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done_val && k < 200) begin
            tick();
            k++;
        end
        n_checks++;
        if (done_val !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: done_val=%b required 1", name, done_val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({cmd_rdy, req_val, resp_rdy, done_val} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_vr: got %b required 1000",
                     {cmd_rdy, req_val, resp_rdy, done_val});
        end
        n_checks++;
        if (req_msg !== 32'd0 || done_msg !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_msg: req=%h done=%h required 0 0",
                     req_msg, done_msg);
        end
    endtask

    task automatic test_basic();
        int base;
        base = log_n;
        req_rdy  = 1'b1;
        done_rdy = 1'b0;
        send_cmd(16'd15, 16'd5, 16'd3);
        n_checks++;
        if (req_val !== 1'b1 || req_msg !== {16'd15, 16'd5}) begin
            n_fail++;
            $display("FAIL basic_first_req: val=%b msg=%h required 1 000f0005",
                     req_val, req_msg);
        end
        wait_done("basic");
        n_checks++;
        if (done_msg !== 32'd7) begin
            n_fail++;
            $display("FAIL basic_sum: got %0d required 7", done_msg);
        end
        n_checks++;
        if (log_n - base !== 3 || log_mem[base] !== {16'd15, 16'd5} ||
            log_mem[base+1] !== {16'd16, 16'd5} ||
            log_mem[base+2] !== {16'd17, 16'd5}) begin
            n_fail++;
            $display("FAIL basic_reqs: n=%0d got %h %h %h required 3 000f0005 00100005 00110005",
                     log_n - base, log_mem[base], log_mem[base+1], log_mem[base+2]);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        n_checks++;
        if (cmd_rdy !== 1'b1 || done_val !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_back_idle: cmd_rdy=%b done_val=%b required 1 0",
                     cmd_rdy, done_val);
        end
    endtask

    task automatic test_empty();
        int base;
        base = log_n;
        send_cmd(16'd9, 16'd3, 16'd0);
        n_checks++;
        if (done_val !== 1'b1 || done_msg !== 32'd0 || req_val !== 1'b0) begin
            n_fail++;
            $display("FAIL empty: done_val=%b done_msg=%h req_val=%b required 1 0 0",
                     done_val, done_msg, req_val);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        n_checks++;
        if (log_n !== base || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_noreq: reqs=%0d cmd_rdy=%b required 0 1",
                     log_n - base, cmd_rdy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        req_rdy = 1'b1;
        send_cmd(16'd20, 16'd8, 16'd4);
        tick();
        req_rdy = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (req_val !== 1'b1 || req_msg !== {16'd21, 16'd8} ||
                done_val !== 1'b0) begin
                ok = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_stall: last val=%b msg=%h done=%b required 1 00150008 0",
                     req_val, req_msg, done_val);
        end
        req_rdy = 1'b1;
        wait_done("bp");
        n_checks++;
        if (done_msg !== 32'd8 || resp_rdy !== 1'b0 || req_val !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_sum: sum=%0d resp_rdy=%b req_val=%b required 8 0 0",
                     done_msg, resp_rdy, req_val);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
    endtask

    task automatic test_wrap();
        int base;
        base = log_n;
        send_cmd(16'hFFFF, 16'd4, 16'd2);
        wait_done("wrap");
        n_checks++;
        if (done_msg !== 32'd5) begin
            n_fail++;
            $display("FAIL wrap_sum: got %0d required 5", done_msg);
        end
        n_checks++;
        if (log_mem[base] !== 32'hFFFF_0004 ||
            log_mem[base+1] !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL wrap_reqs: got %h %h required ffff0004 00000004",
                     log_mem[base], log_mem[base+1]);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
    endtask

    task automatic test_done_backpressure();
        bit ok;
        send_cmd(16'd6, 16'd4, 16'd1);
        wait_done("dbp");
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done_val !== 1'b1 || done_msg !== 32'd2 || cmd_rdy !== 1'b0) begin
                ok = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dbp_hold: done_val=%b msg=%0d cmd_rdy=%b required 1 2 0",
                     done_val, done_msg, cmd_rdy);
        end
        done_rdy = 1'b1;
        n_checks++;
        if (cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL dbp_fire_cycle: cmd_rdy=%b required 0", cmd_rdy);
        end
        tick();
        done_rdy = 1'b0;
        n_checks++;
        if (cmd_rdy !== 1'b1 || done_val !== 1'b0) begin
            n_fail++;
            $display("FAIL dbp_after: cmd_rdy=%b done_val=%b required 1 0",
                     cmd_rdy, done_val);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = log_n;
        req_rdy = 1'b1;
        send_cmd(16'd30, 16'd10, 16'd5);
        tick();
        tick();
        n_checks++;
        if (log_n - base !== 2) begin
            n_fail++;
            $display("FAIL mid_issued: got %0d required 2", log_n - base);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({cmd_rdy, req_val, resp_rdy, done_val} !== 4'b1000 ||
            req_msg !== 32'd0 || done_msg !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: vr=%b req=%h done=%h required 1000 0 0",
                     {cmd_rdy, req_val, resp_rdy, done_val}, req_msg, done_msg);
        end
        send_cmd(16'd12, 16'd8, 16'd1);
        wait_done("mid_new");
        n_checks++;
        if (done_msg !== 32'd4) begin
            n_fail++;
            $display("FAIL mid_new_sum: got %0d required 4", done_msg);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        cmd_val  = 1'b0;
        cmd_msg  = '0;
        req_rdy  = 1'b0;
        done_rdy = 1'b0;
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_wrap();
        test_done_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
